sprite_shifter_bank: RTL

- Parametrised per-scanline sprite pixel generator; successor to the fixed 8-slot, 2-bpp sprite shifter set.
- Holds NUM_SPR sprite slots, loaded in order through a valid/ready port during sprite fetch.
- During the visible line, each slot counts down its X, then emits 8 pixels, with per-slot horizontal flip, a bounded 8-pixel window and a sprite-0 opaque flag.
- Output feeds the PPU pixel mux alongside the background pipeline.

---
 rtl/sprite_shifter_bank.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sprite_shifter_bank.sv
// Per-scanline sprite shifter bank: in-order slot loading, X countdown,
// 8-pixel shift-out with optional flip, lowest-slot priority mux.
module sprite_shifter_bank #(
    parameter int NUM_SPR = 8,
    parameter int BPP     = 2,
    parameter int PAL_W   = 2,
    parameter int XW      = 8,
    parameter int CW      = $clog2(NUM_SPR + 1)
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_ce,
    input  logic               i_enable,
    input  logic               i_line_start,
    input  logic               i_ld_valid,
    output logic               o_ld_ready,
    input  logic [XW-1:0]      i_ld_x,
    input  logic [8*BPP-1:0]   i_ld_pat,
    input  logic [PAL_W-1:0]   i_ld_pal,
    input  logic               i_ld_prio,
    input  logic               i_ld_hflip,
    input  logic               i_ld_id0,
    output logic [BPP-1:0]     o_pix,
    output logic [PAL_W-1:0]   o_pal,
    output logic               o_prio,
    output logic               o_spr0,
    output logic [CW-1:0]      o_count,
    output logic               o_full,
    output logic               o_ovf
);

    logic [NUM_SPR-1:0]      valid;
    logic [NUM_SPR-1:0]      done;
    logic [NUM_SPR-1:0]      prio;
    logic [NUM_SPR-1:0]      hflip;
    logic [NUM_SPR-1:0]      id0;
    logic [NUM_SPR-1:0]      active;
    logic [XW-1:0]           xc   [NUM_SPR];
    logic [2:0]              idx  [NUM_SPR];
    logic [BPP-1:0][7:0]     sh   [NUM_SPR];
    logic [PAL_W-1:0]        pal  [NUM_SPR];
    logic [BPP-1:0]          spix [NUM_SPR];
    logic [CW-1:0]           count;
    logic                    ovf;
    logic                    full;
    logic                    fire;
    logic                    ovf_set;
    logic                    found;

    assign full       = (count == CW'(NUM_SPR));
    assign o_full     = full;
    assign o_ld_ready = !full;
    assign o_count    = count;
    assign o_ovf      = ovf;

    // line_start wins over load and overflow in the same cycle
    assign fire    = i_ce && i_ld_valid && !full && !i_line_start;
    assign ovf_set = i_ce && i_ld_valid && full && !i_line_start;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            count <= '0;
            ovf   <= 1'b0;
            valid <= '0;
            done  <= '0;
            prio  <= '0;
            hflip <= '0;
            id0   <= '0;
            for (int i = 0; i < NUM_SPR; i++) begin
                xc[i]  <= '0;
                idx[i] <= '0;
                sh[i]  <= '0;
                pal[i] <= '0;
            end
        end else if (i_ce) begin
            if (i_line_start) begin
                count <= '0;
                ovf   <= 1'b0;
                valid <= '0;
                done  <= '0;
            end else begin
                if (ovf_set)
                    ovf <= 1'b1;
                if (fire)
                    count <= count + 1'b1;
                for (int i = 0; i < NUM_SPR; i++) begin
                    if (fire && count == CW'(i)) begin
                        valid[i] <= 1'b1;
                        done[i]  <= 1'b0;
                        idx[i]   <= '0;
                        xc[i]    <= i_ld_x;
                        sh[i]    <= i_ld_pat;
                        pal[i]   <= i_ld_pal;
                        prio[i]  <= i_ld_prio;
                        hflip[i] <= i_ld_hflip;
                        id0[i]   <= i_ld_id0;
                    end else if (valid[i] && i_enable) begin
                        if (xc[i] != '0) begin
                            xc[i] <= xc[i] - 1'b1;
                        end else if (!done[i]) begin
                            idx[i] <= idx[i] + 3'd1;
                            if (idx[i] == 3'd7)
                                done[i] <= 1'b1;
                            for (int p = 0; p < BPP; p++) begin
                                if (hflip[i])
                                    sh[i][p] <= {1'b0, sh[i][p][7:1]};
                                else
                                    sh[i][p] <= {sh[i][p][6:0], 1'b0};
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SPR; i++) begin
            active[i] = valid[i] && (xc[i] == '0) && !done[i];
            spix[i]   = '0;
            for (int p = 0; p < BPP; p++)
                spix[i][p] = hflip[i] ? sh[i][p][0] : sh[i][p][7];
            if (!active[i])
                spix[i] = '0;
        end
    end

    // sprite-0 hit looks at every slot, independent of the winner
    always_comb begin
        o_pix  = '0;
        o_pal  = '0;
        o_prio = 1'b0;
        o_spr0 = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < NUM_SPR; i++) begin
            if (id0[i] && spix[i] != '0)
                o_spr0 = 1'b1;
            if (!found && spix[i] != '0) begin
                found  = 1'b1;
                o_pix  = spix[i];
                o_pal  = pal[i];
                o_prio = prio[i];
            end
        end
    end

endmodule
